// File: rtl/func_arb_pkg.sv
// Shared types and sizing helpers for func_call_arbiter and its grant picker.
package func_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } arb_state_e;

    // Wait counter must hold FUNC_LATENCY-1; sized for FUNC_LATENCY+1 values.
    function automatic int cnt_width(input int latency);
        return (latency < 1) ? 1 : $clog2(latency + 1);
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/func_arb_picker.sv
// Combinational one-hot grant: first set request found searching upward from ptr_i (wrapping).
module func_arb_picker
    import func_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IW      = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    logic [IW:0] pos;
    logic        found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        pos   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, ptr_i} + (IW+1)'(k);
            if (pos >= (IW+1)'(NUM_REQ)) begin
                pos = pos - (IW+1)'(NUM_REQ);
            end
            if (!found && req_i[pos[IW-1:0]]) begin
                gnt_o[pos[IW-1:0]] = 1'b1;
                found              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/func_call_arbiter.sv
// Shares one fixed-latency function instance between NUM_REQ callers, one call in flight.
// FUNC_ARB_ROUND_ROBIN_EN selects round-robin arbitration; otherwise lowest index wins.
module func_call_arbiter
    import func_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 32,
    parameter int FUNC_LATENCY = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]         resp_result,
    output logic                      f_start,
    output logic [DATA_W-1:0]         f_a,
    output logic [DATA_W-1:0]         f_b,
    input  logic [DATA_W-1:0]         f_result,
    output logic                      busy
);

    localparam int IW = idx_width(NUM_REQ);
    localparam int CW = cnt_width(FUNC_LATENCY);

    arb_state_e         state_q, state_d;
    logic [IW-1:0]      gidx_q, gidx_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [DATA_W-1:0]  fa_q, fa_d;
    logic [DATA_W-1:0]  fb_q, fb_d;
    logic [DATA_W-1:0]  res_q, res_d;

    logic [NUM_REQ-1:0] gnt;
    logic [IW-1:0]      gnt_idx;
    logic [DATA_W-1:0]  gnt_a, gnt_b;
    logic [IW-1:0]      ptr;

`ifdef FUNC_ARB_ROUND_ROBIN_EN
    logic [IW-1:0] ptr_q, ptr_d;

    assign ptr = ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == IDLE && (|gnt)) begin
            ptr_d = (gnt_idx == IW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign ptr = '0;
`endif

    func_arb_picker #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_picker (
        .req_i (req_valid),
        .ptr_i (ptr),
        .gnt_o (gnt)
    );

    always_comb begin
        gnt_idx = '0;
        gnt_a   = '0;
        gnt_b   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (gnt[k]) begin
                gnt_idx = IW'(k);
                gnt_a   = req_a[k*DATA_W +: DATA_W];
                gnt_b   = req_b[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gidx_d  = gidx_q;
        cnt_d   = cnt_q;
        fa_d    = fa_q;
        fb_d    = fb_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (|gnt) begin
                    gidx_d  = gnt_idx;
                    fa_d    = gnt_a;
                    fb_d    = gnt_b;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CW'(FUNC_LATENCY - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    res_d   = f_result;
                    state_d = RESPOND;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gidx_q  <= '0;
            cnt_q   <= '0;
            fa_q    <= '0;
            fb_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
            cnt_q   <= cnt_d;
            fa_q    <= fa_d;
            fb_q    <= fb_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        resp_valid = '0;
        if (state_q == RESPOND) begin
            resp_valid[gidx_q] = 1'b1;
        end
    end

    assign req_ready   = (state_q == IDLE) ? gnt : '0;
    assign f_start     = (state_q == ISSUE);
    assign f_a         = fa_q;
    assign f_b         = fb_q;
    assign resp_result = res_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_func_call_arbiter.sv
// Directed bench for func_call_arbiter: main DUT at latency 2, plus latency 1 and 5 instances.
module tb_func_call_arbiter;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    req_valid;
    logic [4*DW-1:0] req_a, req_b;

    logic [3:0]    rdy2, rv2, rdy1, rv1, rdy5, rv5;
    logic [DW-1:0] rr2, fa2, fb2, fres2;
    logic [DW-1:0] rr1, fa1, fb1, fres1;
    logic [DW-1:0] rr5, fa5, fb5, fres5;
    logic          fs2, fs1, fs5, busy2, busy1, busy5;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    func_call_arbiter #(.NUM_REQ(4), .DATA_W(DW), .FUNC_LATENCY(2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(rdy2), .resp_valid(rv2), .resp_result(rr2), .f_start(fs2),
        .f_a(fa2), .f_b(fb2), .f_result(fres2), .busy(busy2));

    func_call_arbiter #(.NUM_REQ(4), .DATA_W(DW), .FUNC_LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(rdy1), .resp_valid(rv1), .resp_result(rr1), .f_start(fs1),
        .f_a(fa1), .f_b(fb1), .f_result(fres1), .busy(busy1));

    func_call_arbiter #(.NUM_REQ(4), .DATA_W(DW), .FUNC_LATENCY(5)) u_l5 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(rdy5), .resp_valid(rv5), .resp_result(rr5), .f_start(fs5),
        .f_a(fa5), .f_b(fb5), .f_result(fres5), .busy(busy5));

    // Function model: result = f_a captured at f_start, delayed LATENCY cycles; all-ones otherwise.
    logic [DW-1:0] p1;
    logic [DW-1:0] p2 [2];
    logic [DW-1:0] p5 [5];

    always @(posedge clk) begin
        p1    <= fs1 ? fa1 : '1;
        p2[0] <= fs2 ? fa2 : '1;
        p2[1] <= p2[0];
        p5[0] <= fs5 ? fa5 : '1;
        for (int i = 1; i < 5; i++) p5[i] <= p5[i-1];
    end

    assign fres1 = p1;
    assign fres2 = p2[1];
    assign fres5 = p5[4];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Runs one call on the main DUT; lat = cycle (after transfer edge) where resp_valid is seen, -1 on timeout.
    task automatic do_call(input int idx, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           output int lat, output logic [3:0] rv, output logic [DW-1:0] res);
        int waited;
        lat = -1;
        rv  = '0;
        res = '0;
        req_valid[idx]        = 1'b1;
        req_a[idx*DW +: DW]   = a;
        req_b[idx*DW +: DW]   = b;
        #1;
        waited = 0;
        while (!rdy2[idx] && waited < 20) begin
            tick;
            waited++;
        end
        if (!rdy2[idx]) begin
            req_valid[idx] = 1'b0;
            return;
        end
        tick;
        req_valid[idx] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (rv2 != 4'b0) begin
                lat = k;
                rv  = rv2;
                res = rr2;
                tick;
                return;
            end
            tick;
        end
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        tick;
        tick;
        reset = 1'b0;
        n_checks++; if (rdy2 !== 4'b0)  begin n_fail++; $display("FAIL reset_req_ready got %b expected 0000", rdy2); end
        n_checks++; if (rv2 !== 4'b0)   begin n_fail++; $display("FAIL reset_resp_valid got %b expected 0000", rv2); end
        n_checks++; if (rr2 !== '0)     begin n_fail++; $display("FAIL reset_resp_result got %0d expected 0", rr2); end
        n_checks++; if (fs2 !== 1'b0)   begin n_fail++; $display("FAIL reset_f_start got %b expected 0", fs2); end
        n_checks++; if (fa2 !== '0)     begin n_fail++; $display("FAIL reset_f_a got %0d expected 0", fa2); end
        n_checks++; if (fb2 !== '0)     begin n_fail++; $display("FAIL reset_f_b got %0d expected 0", fb2); end
        n_checks++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b expected 0", busy2); end
    endtask

    task automatic test_single_call;
        int lat1, lat2, lat5, nstart;
        logic [3:0] v1, v2, v5;
        logic [DW-1:0] r1, r2, r5;
        lat1 = -1; lat2 = -1; lat5 = -1; nstart = 0;
        v1 = '0; v2 = '0; v5 = '0; r1 = '0; r2 = '0; r5 = '0;
        req_valid     = 4'b0001;
        req_a[0+:DW]  = 32'd10;
        req_b[0+:DW]  = 32'd20;
        #1;
        n_checks++; if (rdy2 !== 4'b0001) begin n_fail++; $display("FAIL single_grant got %b expected 0001", rdy2); end
        tick;
        req_valid = '0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 1) begin
                n_checks++; if (fa2 !== 32'd10) begin n_fail++; $display("FAIL single_f_a got %0d expected 10", fa2); end
                n_checks++; if (fb2 !== 32'd20) begin n_fail++; $display("FAIL single_f_b got %0d expected 20", fb2); end
                n_checks++; if (fs2 !== 1'b1)   begin n_fail++; $display("FAIL single_f_start_cycle1 got %b expected 1", fs2); end
            end
            if (fs2) nstart++;
            if (rv2 != 4'b0 && lat2 < 0) begin lat2 = k; v2 = rv2; r2 = rr2; end
            if (rv1 != 4'b0 && lat1 < 0) begin lat1 = k; v1 = rv1; r1 = rr1; end
            if (rv5 != 4'b0 && lat5 < 0) begin lat5 = k; v5 = rv5; r5 = rr5; end
            tick;
        end
        n_checks++; if (nstart !== 1)       begin n_fail++; $display("FAIL single_start_count got %0d expected 1", nstart); end
        n_checks++; if (lat2 !== 4)         begin n_fail++; $display("FAIL single_lat2 got %0d expected 4", lat2); end
        n_checks++; if (v2 !== 4'b0001)     begin n_fail++; $display("FAIL single_resp_valid got %b expected 0001", v2); end
        n_checks++; if (r2 !== 32'd10)      begin n_fail++; $display("FAIL single_result got %0d expected 10", r2); end
        n_checks++; if (lat1 !== 3)         begin n_fail++; $display("FAIL sweep_lat1 got %0d expected 3", lat1); end
        n_checks++; if (v1 !== 4'b0001 || r1 !== 32'd10) begin n_fail++; $display("FAIL sweep_l1_resp got %b/%0d expected 0001/10", v1, r1); end
        n_checks++; if (lat5 !== 7)         begin n_fail++; $display("FAIL sweep_lat5 got %0d expected 7", lat5); end
        n_checks++; if (v5 !== 4'b0001 || r5 !== 32'd10) begin n_fail++; $display("FAIL sweep_l5_resp got %b/%0d expected 0001/10", v5, r5); end
    endtask

    // A call from requester 1; under round-robin this leaves the pointer at 2.
    task automatic test_call_req1;
        int lat;
        logic [3:0] rv;
        logic [DW-1:0] res;
        do_call(1, 32'd3, 32'd0, lat, rv, res);
        n_checks++; if (lat !== 4)        begin n_fail++; $display("FAIL req1_latency got %0d expected 4", lat); end
        n_checks++; if (rv !== 4'b0010)   begin n_fail++; $display("FAIL req1_resp_valid got %b expected 0010", rv); end
        n_checks++; if (res !== 32'd3)    begin n_fail++; $display("FAIL req1_result got %0d expected 3", res); end
    endtask

    task automatic test_contention;
        int order [2];
        logic [DW-1:0] res [2];
        int n, e0, e1;
        logic [3:0] drop;
`ifdef FUNC_ARB_ROUND_ROBIN_EN
        e0 = 3; e1 = 1;
`else
        e0 = 1; e1 = 3;
`endif
        n = 0;
        order[0] = -1; order[1] = -1; res[0] = '0; res[1] = '0;
        req_a[1*DW +: DW] = 32'd7;
        req_a[3*DW +: DW] = 32'd9;
        req_valid = 4'b1010;
        for (int c = 0; c < 40 && n < 2; c++) begin
            #1;
            if (rv2 != 4'b0) begin
                for (int i = 0; i < 4; i++) if (rv2[i]) order[n] = i;
                res[n] = rr2;
                n++;
            end
            drop = rdy2 & req_valid;
            tick;
            req_valid = req_valid & ~drop;
        end
        req_valid = '0;
        n_checks++; if (n !== 2)                    begin n_fail++; $display("FAIL contention_count got %0d expected 2", n); end
        n_checks++; if (order[0] !== e0)            begin n_fail++; $display("FAIL contention_first got %0d expected %0d", order[0], e0); end
        n_checks++; if (res[0] !== 32'(7 + (e0-1))) begin n_fail++; $display("FAIL contention_res0 got %0d expected %0d", res[0], 7 + (e0-1)); end
        n_checks++; if (order[1] !== e1)            begin n_fail++; $display("FAIL contention_second got %0d expected %0d", order[1], e1); end
        n_checks++; if (res[1] !== 32'(7 + (e1-1))) begin n_fail++; $display("FAIL contention_res1 got %0d expected %0d", res[1], 7 + (e1-1)); end
    endtask

    task automatic test_reset_mid_call;
        int nresp, lat;
        logic [3:0] rv;
        logic [DW-1:0] res;
        req_valid[0]  = 1'b1;
        req_a[0+:DW]  = 32'd77;
        #1;
        tick;
        req_valid = '0;
        tick;
        n_checks++; if (busy2 !== 1'b1) begin n_fail++; $display("FAIL midreset_busy_before got %b expected 1", busy2); end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        n_checks++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL midreset_busy_after got %b expected 0", busy2); end
        n_checks++; if (fs2 !== 1'b0)   begin n_fail++; $display("FAIL midreset_f_start got %b expected 0", fs2); end
        n_checks++; if (fa2 !== '0)     begin n_fail++; $display("FAIL midreset_f_a got %0d expected 0", fa2); end
        nresp = 0;
        for (int k = 0; k < 8; k++) begin
            if (rv2 != 4'b0) nresp++;
            tick;
        end
        n_checks++; if (nresp !== 0) begin n_fail++; $display("FAIL midreset_no_resp got %0d expected 0", nresp); end
        do_call(3, 32'd5, 32'd0, lat, rv, res);
        n_checks++; if (res !== 32'd5)  begin n_fail++; $display("FAIL midreset_next_result got %0d expected 5", res); end
        n_checks++; if (rv !== 4'b1000) begin n_fail++; $display("FAIL midreset_next_valid got %b expected 1000", rv); end
        n_checks++; if (lat !== 4)      begin n_fail++; $display("FAIL midreset_next_lat got %0d expected 4", lat); end
    endtask

    task automatic test_back_to_back;
        int order [8];
        int cyc [8];
        logic [DW-1:0] res [8];
        int n, exp_i;
        for (int i = 0; i < 8; i++) begin order[i] = -1; cyc[i] = 0; res[i] = '0; end
        for (int i = 0; i < 4; i++) req_a[i*DW +: DW] = 32'(100 + i);
        req_valid = 4'b1111;
        n = 0;
        for (int c = 0; c < 80 && n < 8; c++) begin
            if (rv2 != 4'b0) begin
                for (int i = 0; i < 4; i++) if (rv2[i]) order[n] = i;
                res[n] = rr2;
                cyc[n] = c;
                n++;
                if (n == 8) req_valid = '0;
            end
            tick;
        end
        req_valid = '0;
        n_checks++; if (n !== 8) begin n_fail++; $display("FAIL b2b_count got %0d expected 8", n); end
        for (int i = 0; i < 8; i++) begin
`ifdef FUNC_ARB_ROUND_ROBIN_EN
            exp_i = i % 4;
`else
            exp_i = 0;
`endif
            n_checks++; if (order[i] !== exp_i) begin n_fail++; $display("FAIL b2b_order[%0d] got %0d expected %0d", i, order[i], exp_i); end
            n_checks++; if (res[i] !== 32'(100 + exp_i)) begin n_fail++; $display("FAIL b2b_result[%0d] got %0d expected %0d", i, res[i], 100 + exp_i); end
            if (i > 0) begin
                n_checks++; if (cyc[i] - cyc[i-1] !== 5) begin n_fail++; $display("FAIL b2b_spacing[%0d] got %0d expected 5", i, cyc[i] - cyc[i-1]); end
            end
        end
        tick;
    endtask

    task automatic test_withdrawn;
        int g2, r2cnt, r0cnt, notbusy;
        logic [DW-1:0] last;
        g2 = 0; r2cnt = 0; r0cnt = 0; notbusy = 0; last = '0;
        req_valid[0]  = 1'b1;
        req_a[0+:DW]  = 32'd42;
        req_a[2*DW +: DW] = 32'hBAD;
        #1;
        tick;
        req_valid = '0;
        for (int c = 1; c <= 3; c++) begin
            if (!busy2) notbusy++;
            req_valid[2] = 1'b1;
            #1;
            if (rdy2 != 4'b0) g2++;
            tick;
        end
        req_valid = '0;
        for (int k = 0; k < 10; k++) begin
            if (rv2[2]) r2cnt++;
            if (rv2[0]) begin r0cnt++; last = rr2; end
            if (rdy2[2]) g2++;
            tick;
        end
        n_checks++; if (notbusy !== 0) begin n_fail++; $display("FAIL withdrawn_busy got %0d idle cycles expected 0", notbusy); end
        n_checks++; if (g2 !== 0)      begin n_fail++; $display("FAIL withdrawn_grant got %0d expected 0", g2); end
        n_checks++; if (r2cnt !== 0)   begin n_fail++; $display("FAIL withdrawn_resp2 got %0d expected 0", r2cnt); end
        n_checks++; if (r0cnt !== 1)   begin n_fail++; $display("FAIL withdrawn_resp0 got %0d expected 1", r0cnt); end
        n_checks++; if (last !== 32'd42) begin n_fail++; $display("FAIL withdrawn_result got %0d expected 42", last); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_single_call;
        test_call_req1;
        test_contention;
        test_reset_mid_call;
        test_back_to_back;
        test_withdrawn;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
